// File: rtl/micro_sequencer.sv
// Microcode sequencer: fixed two-word fetch, opcode capture with same-cycle bypass,
// and T-state stepping that addresses an external asynchronous microcode ROM.
module micro_sequencer #(
    parameter logic [15:0] FETCH0 = 16'h8040,
    parameter logic [15:0] FETCH1 = 16'hB480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [15:0] bus,
    input  logic [15:0] rom_data,
    output logic [10:0] rom_addr,
    output logic [15:0] uinstr,
    output logic [2:0]  tstate,
    output logic [7:0]  opcode
);

    logic [15:0] uinstr_q, uinstr_d;
    logic [2:0]  tstate_q, tstate_d;
    logic [7:0]  opcode_q, opcode_d;
    logic        rt, ii;

    // RT shares bit11 with the ALU NY flag, so it only counts when EO is inactive
    always_comb begin
        rt = uinstr_q[15] & uinstr_q[11];
        ii = (uinstr_q[8:6] == 3'b010);
    end

    always_comb begin
        opcode_d = opcode_q;
        if (ii) begin
            opcode_d = bus[15:8];
        end

        tstate_d = tstate_q + 3'd1;
        if (rt || (tstate_q == 3'd7)) begin
            tstate_d = '0;
        end

        case (tstate_d)
            3'd0:    uinstr_d = FETCH0;
            3'd1:    uinstr_d = FETCH1;
            default: uinstr_d = rom_data;
        endcase

        rom_addr = {opcode_d, tstate_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uinstr_q <= FETCH0;
            tstate_q <= '0;
            opcode_q <= '0;
        end else if (!stall) begin
            uinstr_q <= uinstr_d;
            tstate_q <= tstate_d;
            opcode_q <= opcode_d;
        end
    end

    assign uinstr = uinstr_q;
    assign tstate = tstate_q;
    assign opcode = opcode_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: the driver queues the expected per-cycle view,
// the monitor pops and compares it at each falling edge.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [15:0] bus;
    logic [15:0] rom_data;
    logic [10:0] rom_addr;
    logic [15:0] uinstr;
    logic [2:0]  tstate;
    logic [7:0]  opcode;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        string       name;
        logic [2:0]  t;
        logic [15:0] u;
        logic [7:0]  op;
        logic [10:0] addr;
    } exp_t;

    exp_t sb[$];

    micro_sequencer #(
        .FETCH0(16'h8040),
        .FETCH1(16'hB480)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .bus     (bus),
        .rom_data(rom_data),
        .rom_addr(rom_addr),
        .uinstr  (uinstr),
        .tstate  (tstate),
        .opcode  (opcode)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: registered outputs reflect the last edge, rom_addr the current inputs
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".tstate"}, {13'd0, tstate}, {13'd0, e.t});
            check({e.name, ".uinstr"}, uinstr, e.u);
            check({e.name, ".opcode"}, {8'd0, opcode}, {8'd0, e.op});
            check({e.name, ".rom_addr"}, {5'd0, rom_addr}, {5'd0, e.addr});
        end
    end

    task automatic cyc(input logic rst, input logic st, input logic [15:0] b,
                       input logic [15:0] rd, input logic [2:0] et, input logic [15:0] eu,
                       input logic [7:0] eo, input logic [10:0] ea, input string nm);
        exp_t e;
        @(posedge clk);
        #2;
        reset    = rst;
        stall    = st;
        bus      = b;
        rom_data = rd;
        e.name = nm; e.t = et; e.u = eu; e.op = eo; e.addr = ea;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b1; bus = '0; rom_data = '0;
        //  rst  st   bus       rom       t     uinstr    op     addr
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'h8040, 8'h00, 11'h001, "reset");
        cyc(1'b0, 1'b0, 16'h1234, 16'h8040, 3'd1, 16'hB480, 8'h00, 11'h092, "t1_bypass");
        cyc(1'b0, 1'b0, 16'h0000, 16'h8800, 3'd2, 16'h8040, 8'h12, 11'h093, "t2_capture");
        cyc(1'b0, 1'b0, 16'h0000, 16'hFFFF, 3'd3, 16'h8800, 8'h12, 11'h090, "rt_word");
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'h8040, 8'h12, 11'h091, "rt_restart");
        cyc(1'b0, 1'b0, 16'h5678, 16'h0800, 3'd1, 16'hB480, 8'h12, 11'h2B2, "b_t1");
        cyc(1'b0, 1'b0, 16'h0000, 16'h1000, 3'd2, 16'h0800, 8'h56, 11'h2B3, "eo_not_rt");
        cyc(1'b0, 1'b0, 16'h0000, 16'hC100, 3'd3, 16'h1000, 8'h56, 11'h2B4, "b_t3");
        cyc(1'b0, 1'b0, 16'h0000, 16'hA0C0, 3'd4, 16'hC100, 8'h56, 11'h2B5, "b_t4");
        cyc(1'b0, 1'b0, 16'h0000, 16'h9000, 3'd5, 16'hA0C0, 8'h56, 11'h2B6, "b_t5");
        cyc(1'b0, 1'b0, 16'h0000, 16'hB1C0, 3'd6, 16'h9000, 8'h56, 11'h2B7, "b_t6");
        cyc(1'b0, 1'b0, 16'h0000, 16'hFFFF, 3'd7, 16'hB1C0, 8'h56, 11'h2B0, "b_t7_reserved");
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'h8040, 8'h56, 11'h2B1, "wrap");
        cyc(1'b0, 1'b0, 16'hABCD, 16'h0000, 3'd1, 16'hB480, 8'h56, 11'h55A, "c_t1");
        cyc(1'b0, 1'b0, 16'h0000, 16'h1111, 3'd2, 16'h0000, 8'hAB, 11'h55B, "c_t2");
        cyc(1'b0, 1'b0, 16'h0000, 16'h2222, 3'd3, 16'h1111, 8'hAB, 11'h55C, "c_t3");
        cyc(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 3'd4, 16'h2222, 8'hAB, 11'h55D, "stall0");
        cyc(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 3'd4, 16'h2222, 8'hAB, 11'h55D, "stall1");
        cyc(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 3'd4, 16'h2222, 8'hAB, 11'h55D, "stall2");
        cyc(1'b0, 1'b0, 16'h0000, 16'h3333, 3'd4, 16'h2222, 8'hAB, 11'h55D, "stall_end");
        cyc(1'b1, 1'b0, 16'h0000, 16'hFFFF, 3'd5, 16'h3333, 8'hAB, 11'h55E, "c_t5");
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'h8040, 8'h00, 11'h001, "midop_reset");

        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
